// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Load/store controller issuing one data-memory access per
//               request and returning a write-back response.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
  parameter int MEM_WORDS = 64,
  parameter int IDX_W     = 6,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [4:0]       req_rd,
  output logic [31:0]      mem_dataEN,
  output logic [IDX_W-1:0] mem_d,
  output logic             mem_write,
  output logic             mem_read,
  input  logic [31:0]      mem_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic [4:0]       rsp_rd,
  output logic             rsp_wb,
  output logic             rsp_err,
  output logic [CNT_W-1:0] n_loads,
  output logic [CNT_W-1:0] n_stores
);

  localparam logic [1:0]  c_IDLE   = 2'd0;
  localparam logic [1:0]  c_ACCESS = 2'd1;
  localparam logic [1:0]  c_RESP   = 2'd2;
  localparam logic [31:0] c_BYTES  = 32'(4 * MEM_WORDS);

  logic [1:0] r_state;
  logic       w_req_fire;
  logic       w_err;

  // Held low while reset is asserted even though the state register is IDLE.
  assign req_ready  = rst_n && (r_state == c_IDLE);
  assign w_req_fire = req_valid && req_ready;
  assign w_err      = (req_addr[1:0] != 2'b00) || (req_addr >= c_BYTES);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= c_IDLE;
      mem_dataEN <= '0;
      mem_d      <= '0;
      mem_write  <= 1'b0;
      mem_read   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_rd     <= '0;
      rsp_wb     <= 1'b0;
      rsp_err    <= 1'b0;
      n_loads    <= '0;
      n_stores   <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_req_fire) begin
            rsp_rd <= req_rd;
            if (w_err) begin
              r_state   <= c_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_wb    <= 1'b0;
              rsp_rdata <= '0;
            end else begin
              // Strobes are registered here so they are high for the ACCESS cycle.
              r_state    <= c_ACCESS;
              mem_d      <= req_addr[IDX_W+1:2];
              mem_dataEN <= req_wdata;
              mem_write  <= req_we;
              mem_read   <= !req_we;
            end
          end
        end
        c_ACCESS: begin
          r_state    <= c_RESP;
          mem_d      <= '0;
          mem_dataEN <= '0;
          mem_write  <= 1'b0;
          mem_read   <= 1'b0;
          rsp_valid  <= 1'b1;
          rsp_err    <= 1'b0;
          if (mem_read) begin
            rsp_rdata <= mem_data;
            rsp_wb    <= 1'b1;
            n_loads   <= n_loads + CNT_W'(1);
          end else begin
            rsp_rdata <= '0;
            rsp_wb    <= 1'b0;
            n_stores  <= n_stores + CNT_W'(1);
          end
        end
        c_RESP: begin
          if (rsp_ready) begin
            r_state   <= c_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_rd    <= '0;
            rsp_wb    <= 1'b0;
            rsp_err   <= 1'b0;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
